// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Round-robin arbiter that shares one combinational barrel shifter among
//   NUM_REQ requesters. A granted operation is shifted and captured into a
//   single response register, tagged with the id of the requester that
//   issued it. At most one operation is accepted per cycle.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   req_valid    per-requester operation present
//   req_ready    per-requester accept strobe (one-hot or zero)
//   req_in       operands, requester i at [i*WIDTH +: WIDTH]
//   req_sel      shift amounts, requester i at [i*AMT_W +: AMT_W]
//   req_sft_lft  per-requester direction, 1 = left, 0 = right
//   rsp_valid    response register holds a result
//   rsp_ready    consumer takes the response this cycle
//   rsp_out      shifted result
//   rsp_id       requester index that issued rsp_out
//
// Build option
//   SHIFT_ARB_ROTATE_EN  defined: rotate instead of zero-fill shift.
//
// State  | meaning
// IDLE   | response register empty
// FULL   | response register holds an unconsumed result
module shift_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int AMT_W   = $clog2(WIDTH),
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_in,
  input  logic [NUM_REQ*AMT_W-1:0] req_sel,
  input  logic [NUM_REQ-1:0]       req_sft_lft,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_out,
  output logic [ID_W-1:0]          rsp_id
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   next_ptr;
  logic              found;
  logic              can_accept;
  logic              accept;
  logic [WIDTH-1:0]  win_in;
  logic [AMT_W-1:0]  win_sel;
  logic              win_lft;
  logic [WIDTH-1:0]  shifted;

  // Index of the k-th candidate in the round-robin search, wrapped so that
  // non-power-of-2 requester counts still work.
  function automatic int wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  always_comb begin : arb
    int idx;
    idx     = 0;
    found   = 1'b0;
    win     = '0;
    win_in  = '0;
    win_sel = '0;
    win_lft = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap_idx(int'(rr_ptr), k);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        win     = ID_W'(idx);
        win_in  = req_in[idx*WIDTH +: WIDTH];
        win_sel = req_sel[idx*AMT_W +: AMT_W];
        win_lft = req_sft_lft[idx];
      end
    end
  end

  // A full register can still take a new result when it is drained in the
  // same cycle, which gives one operation per clock.
  assign can_accept = (state == IDLE) | ((state == FULL) & rsp_ready);
  assign req_ready  = (can_accept & found & ~rst) ? (NUM_REQ'(1) << win) : '0;
  assign accept     = |req_ready;
  assign next_ptr   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

  always_comb begin : shifter
    logic [2*WIDTH-1:0] dbl;
    dbl     = '0;
    shifted = '0;
`ifdef SHIFT_ARB_ROTATE_EN
    // Doubling the operand lets a plain shift bring wrapped bits back in.
    if (win_lft) begin
      dbl     = {win_in, win_in} << win_sel;
      shifted = dbl[2*WIDTH-1:WIDTH];
    end else begin
      dbl     = {win_in, win_in} >> win_sel;
      shifted = dbl[WIDTH-1:0];
    end
`else
    if (win_lft) begin
      shifted = win_in << win_sel;
    end else begin
      shifted = win_in >> win_sel;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      rsp_out <= '0;
      rsp_id  <= '0;
    end else if (accept) begin
      state   <= FULL;
      rsp_out <= shifted;
      rsp_id  <= win;
      rr_ptr  <= next_ptr;
    end else if ((state == FULL) && rsp_ready) begin
      state   <= IDLE;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int AMT_W   = 2;
  localparam int ID_W    = 2;

`ifdef SHIFT_ARB_ROTATE_EN
  localparam logic [3:0] EXP_L1 = 4'b1011;
`else
  localparam logic [3:0] EXP_L1 = 4'b1010;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_in = '0;
  logic [NUM_REQ*AMT_W-1:0] req_sel = '0;
  logic [NUM_REQ-1:0]       req_sft_lft = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic [WIDTH-1:0]         rsp_out;
  logic [ID_W-1:0]          rsp_id;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] data;
    int         id;
  } exp_t;

  exp_t sb[$];

  shift_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in(req_in), .req_sel(req_sel), .req_sft_lft(req_sft_lft),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  // Bit-by-bit reference shifter.
  function automatic logic [3:0] model_shift(input logic [3:0] x, input int a, input bit lft);
    logic [3:0] r;
    int src;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      src = lft ? b - a : b + a;
`ifdef SHIFT_ARB_ROTATE_EN
      r[b] = x[(src + 4) % 4];
`else
      r[b] = (src >= 0 && src < 4) ? x[src] : 1'b0;
`endif
    end
    return r;
  endfunction

  function automatic logic [3:0] sweep_exp(input int s);
    logic [3:0] x;
    x = 4'b1101;
    return model_shift(x, s, 1'b0);
  endfunction

  // Reference arbiter/scoreboard, sampled on the falling edge.
  int         m_ptr = 0;
  bit         m_full = 1'b0;
  always @(negedge clk) begin
    int         mwin;
    int         idx;
    logic [3:0] exp_rdy;
    exp_t       e;
    exp_t       got;
    if (rst) begin
      m_ptr  = 0;
      m_full = 1'b0;
      sb.delete();
    end else begin
      mwin = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (mwin < 0 && req_valid[idx]) mwin = idx;
      end
      exp_rdy = '0;
      if ((!m_full || rsp_ready) && mwin >= 0) exp_rdy[mwin] = 1'b1;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL mon_req_ready: got %b want %b at %0t", req_ready, exp_rdy, $time);
      end
      n_checks++;
      if (rsp_valid !== m_full) begin
        n_errors++;
        $display("FAIL mon_rsp_valid: got %b want %b at %0t", rsp_valid, m_full, $time);
      end
      if (m_full && rsp_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL mon_sb_empty: got empty queue want entry at %0t", $time);
        end else begin
          got = sb.pop_front();
          if (rsp_out !== got.data || rsp_id !== ID_W'(got.id)) begin
            n_errors++;
            $display("FAIL mon_rsp: got out=%b id=%0d want out=%b id=%0d at %0t",
                     rsp_out, rsp_id, got.data, got.id, $time);
          end
        end
      end
      if (exp_rdy != 0) begin
        e.data = model_shift(req_in[mwin*4 +: 4], int'(req_sel[mwin*2 +: 2]), req_sft_lft[mwin]);
        e.id   = mwin;
        sb.push_back(e);
        m_ptr  = (mwin + 1) % NUM_REQ;
        m_full = 1'b1;
      end else if (m_full && rsp_ready) begin
        m_full = 1'b0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    n_checks++;
    if (rsp_out !== 4'b0000) begin n_errors++; $display("FAIL reset_out: got %b want 0000", rsp_out); end
    n_checks++;
    if (rsp_id !== 2'd0) begin n_errors++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    next_cycle();
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_in[3:0] = 4'b1101; req_sel[1:0] = 2'd1; req_sft_lft[0] = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_out !== EXP_L1 || rsp_id !== 2'd0) begin
      n_errors++;
      $display("FAIL single_rsp: got v=%b out=%b id=%0d want v=1 out=%b id=0", rsp_valid, rsp_out, rsp_id, EXP_L1);
    end
    next_cycle();
  endtask

  task automatic test_right_sweep();
    req_in[11:8] = 4'b1101; req_sft_lft[2] = 1'b0; rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int s = 0; s < 5; s++) begin
      if (s < 4) req_sel[5:4] = 2'(s);
      else req_valid = '0;
      @(negedge clk);
      if (s < 4) begin
        n_checks++;
        if (req_ready !== 4'b0100) begin n_errors++; $display("FAIL sweep_ready%0d: got %b want 0100", s, req_ready); end
      end
      if (s > 0) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_out !== sweep_exp(s - 1) || rsp_id !== 2'd2) begin
          n_errors++;
          $display("FAIL sweep_rsp%0d: got v=%b out=%b id=%0d want v=1 out=%b id=2",
                   s - 1, rsp_valid, rsp_out, rsp_id, sweep_exp(s - 1));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    req_in = 16'h9C63; req_sel = 8'b11_10_01_00; req_sft_lft = 4'b0101;
    rsp_ready = 1'b1; req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) req_valid = '0;
      @(negedge clk);
      if (k < 5) begin
        n_checks++;
        if (req_ready !== 4'(1 << (k % 4))) begin
          n_errors++;
          $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, 4'(1 << (k % 4)));
        end
      end
      if (k >= 1) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4)) begin
          n_errors++;
          $display("FAIL rr_rsp%0d: got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, (k - 1) % 4);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0001; req_in[3:0] = 4'b1101; req_sel[1:0] = 2'd1; req_sft_lft[0] = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL bp_first_ready: got %b want 0001", req_ready); end
    next_cycle();
    req_valid = 4'b0010; req_in[7:4] = 4'b0110; req_sel[3:2] = 2'd0; req_sft_lft[1] = 1'b1;
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_ready%0d: got %b want 0000", c, req_ready); end
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_out !== EXP_L1 || rsp_id !== 2'd0) begin
        n_errors++;
        $display("FAIL bp_hold%0d: got v=%b out=%b id=%0d want v=1 out=%b id=0", c, rsp_valid, rsp_out, rsp_id, EXP_L1);
      end
      next_cycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL bp_release_ready: got %b want 0010", req_ready); end
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_out !== 4'b0110 || rsp_id !== 2'd1) begin
      n_errors++;
      $display("FAIL bp_next_rsp: got v=%b out=%b id=%0d want v=1 out=0110 id=1", rsp_valid, rsp_out, rsp_id);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    req_valid = 4'b1000; req_in[15:12] = 4'b1111; req_sel[7:6] = 2'd1; req_sft_lft[3] = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL midop_grant3: got %b want 1000", req_ready); end
    next_cycle();
    rst = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL midop_in_reset: got ready=%b v=%b want ready=0000 v=1", req_ready, rsp_valid);
    end
    next_cycle();
    rst = 1'b0; req_valid = 4'b1001;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_out !== 4'b0000 || rsp_id !== 2'd0) begin
      n_errors++;
      $display("FAIL midop_cleared: got v=%b out=%b id=%0d want v=0 out=0000 id=0", rsp_valid, rsp_out, rsp_id);
    end
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL midop_ptr0: got %b want 0001", req_ready); end
    next_cycle();
    req_valid = 4'b1000; rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL midop_then3: got %b want 1000", req_ready); end
    next_cycle();
    req_valid = '0;
    next_cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid   = 4'($urandom);
      req_in      = 16'($urandom);
      req_sel     = 8'($urandom);
      req_sft_lft = 4'($urandom);
      rsp_ready   = 1'($urandom_range(0, 1));
      next_cycle();
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) next_cycle();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0 || rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL random_drain: got queue=%0d v=%b want queue=0 v=0", sb.size(), rsp_valid);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_right_sweep();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
